wb_csr_slave: RTL

Wishbone responder (slave) terminating requests issued by the host-side Wishbone pipe bridge. It holds a bank of read/write control registers and exposes a bank of read-only status words. Every decoded request is acknowledged with exactly one single-cycle ack after a fixed, parameterised latency. It sits on the bridge's bus segment in the upper half of the address space (bit 31 = 1).

---
 rtl/wb_csr_slave_pkg.sv | 36 +++
 rtl/wb_csr_slave.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/wb_csr_slave_pkg.sv
// Shared bus widths, state/decode enums and the index classifier for the
// Wishbone CSR responder.
package wb_csr_pkg;

    localparam int WB_DW = 32;
    localparam int WB_AW = 32;

    localparam logic [WB_DW-1:0] UNMAPPED_RDATA = 32'hBADA_DD12;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK
    } state_e;

    typedef enum logic [1:0] {
        CTRL,
        STATUS,
        UNMAPPED
    } idx_class_e;

    // Control words sit first, status words follow, everything above is a hole.
    function automatic idx_class_e classify_idx(input int idx, input int num_ctrl,
                                                input int num_status);
        idx_class_e cls;
        if (idx < num_ctrl) begin
            cls = CTRL;
        end else if (idx < num_ctrl + num_status) begin
            cls = STATUS;
        end else begin
            cls = UNMAPPED;
        end
        return cls;
    endfunction

endpackage

// File: rtl/wb_csr_slave.sv
// Wishbone CSR responder: RW control bank plus RO status window, each hit
// answered by one single-cycle ack after a fixed latency.
module wb_csr_slave
    import wb_csr_pkg::*;
#(
    parameter logic [WB_AW-1:0]          BASE_ADDR   = 32'h8000_0000,
    parameter int                        ADDR_W      = 8,
    parameter int                        NUM_CTRL    = 8,
    parameter int                        NUM_STATUS  = 8,
    parameter int                        ACK_LATENCY = 1,
    parameter logic [NUM_CTRL*WB_DW-1:0] CTRL_RESET  = '0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           wb_cyc_i,
    input  logic                           wb_stb_i,
    input  logic [WB_AW-1:0]               wb_adr_i,
    input  logic [WB_DW-1:0]               wb_dat_i,
    input  logic                           wb_we_i,
    output logic [WB_DW-1:0]               wb_dat_o,
    output logic                           wb_ack_o,
    output logic [NUM_CTRL*WB_DW-1:0]      ctrl_o,
    output logic [NUM_CTRL-1:0]            ctrl_wr_o,
    input  logic [NUM_STATUS*WB_DW-1:0]    status_i,
    output logic [NUM_STATUS-1:0]          status_rd_o
);

    localparam logic [3:0] LAT = 4'(ACK_LATENCY);

    if (NUM_CTRL + NUM_STATUS > (1 << ADDR_W)) begin : g_bad_map
        $error("wb_csr_slave: NUM_CTRL+NUM_STATUS exceeds 2^ADDR_W");
    end
    if (ACK_LATENCY < 0 || ACK_LATENCY > 15) begin : g_bad_latency
        $error("wb_csr_slave: ACK_LATENCY must be 0..15");
    end
    if (BASE_ADDR[ADDR_W-1:0] != '0) begin : g_bad_base
        $error("wb_csr_slave: BASE_ADDR not aligned to 2^ADDR_W");
    end

    state_e                  state_reg, state_next;
    logic [3:0]              cnt_reg, cnt_next;
    logic [ADDR_W-1:0]       idx_reg, idx_next;
    logic                    we_reg, we_next;
    logic [WB_DW-1:0]        wdat_reg, wdat_next;
    logic                    ack_reg, ack_next;
    logic [WB_DW-1:0]        rdata_reg, rdata_next;
    logic [NUM_CTRL-1:0]     ctrl_wr_reg, ctrl_wr_next;
    logic [NUM_STATUS-1:0]   status_rd_reg, status_rd_next;

    logic                    hit;
    idx_class_e              idx_class;
    logic [NUM_CTRL-1:0]     ctrl_sel;
    logic [NUM_STATUS-1:0]   status_sel;
    logic [WB_DW-1:0]        ctrl_rd_word;
    logic [WB_DW-1:0]        status_rd_word;

    assign hit = wb_cyc_i & wb_stb_i &
                 (wb_adr_i[WB_AW-1:ADDR_W] == BASE_ADDR[WB_AW-1:ADDR_W]);

    assign idx_class = classify_idx(32'(idx_reg), NUM_CTRL, NUM_STATUS);

    // One-hot selects of the captured index, reused for read muxing and strobes.
    for (genvar gi = 0; gi < NUM_CTRL; gi++) begin : g_ctrl_sel
        assign ctrl_sel[gi] = (idx_reg == ADDR_W'(gi));
    end
    for (genvar gi = 0; gi < NUM_STATUS; gi++) begin : g_status_sel
        assign status_sel[gi] = (idx_reg == ADDR_W'(NUM_CTRL + gi));
    end

    always_comb begin
        ctrl_rd_word   = '0;
        status_rd_word = '0;
        for (int k = 0; k < NUM_CTRL; k++) begin
            if (ctrl_sel[k]) begin
                ctrl_rd_word = ctrl_rd_word | ctrl_o[k*WB_DW +: WB_DW];
            end
        end
        for (int k = 0; k < NUM_STATUS; k++) begin
            if (status_sel[k]) begin
                status_rd_word = status_rd_word | status_i[k*WB_DW +: WB_DW];
            end
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        idx_next       = idx_reg;
        we_next        = we_reg;
        wdat_next      = wdat_reg;
        ack_next       = 1'b0;
        rdata_next     = rdata_reg;
        ctrl_wr_next   = '0;
        status_rd_next = '0;

        case (state_reg)
            IDLE: begin
                // The cycle carrying ack is still busy; new hits wait until it drops.
                if (hit && !ack_reg) begin
                    idx_next  = wb_adr_i[ADDR_W-1:0];
                    we_next   = wb_we_i;
                    wdat_next = wb_dat_i;
                    if (LAT == 4'd0) begin
                        state_next = ACK;
                    end else begin
                        cnt_next   = LAT;
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!wb_cyc_i) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt_reg == 4'd1) begin
                    state_next = ACK;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            ACK: begin
                // The edge leaving this state raises ack, so commits happen here.
                state_next = IDLE;
                if (wb_cyc_i) begin
                    ack_next = 1'b1;
                    if (we_reg) begin
                        rdata_next = '0;
                        if (idx_class == CTRL) begin
                            ctrl_wr_next = ctrl_sel;
                        end
                    end else begin
                        case (idx_class)
                            CTRL: rdata_next = ctrl_rd_word;
                            STATUS: begin
                                rdata_next     = status_rd_word;
                                status_rd_next = status_sel;
                            end
                            default: rdata_next = UNMAPPED_RDATA;
                        endcase
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            idx_reg       <= '0;
            we_reg        <= 1'b0;
            wdat_reg      <= '0;
            ack_reg       <= 1'b0;
            rdata_reg     <= '0;
            ctrl_wr_reg   <= '0;
            status_rd_reg <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            idx_reg       <= idx_next;
            we_reg        <= we_next;
            wdat_reg      <= wdat_next;
            ack_reg       <= ack_next;
            rdata_reg     <= rdata_next;
            ctrl_wr_reg   <= ctrl_wr_next;
            status_rd_reg <= status_rd_next;
        end
    end

    for (genvar gi = 0; gi < NUM_CTRL; gi++) begin : g_ctrl
        logic [WB_DW-1:0] ctrl_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ctrl_reg <= CTRL_RESET[gi*WB_DW +: WB_DW];
            end else if (ctrl_wr_next[gi]) begin
                ctrl_reg <= wdat_reg;
            end
        end

        assign ctrl_o[gi*WB_DW +: WB_DW] = ctrl_reg;
    end

    assign wb_ack_o    = ack_reg;
    assign wb_dat_o    = rdata_reg;
    assign ctrl_wr_o   = ctrl_wr_reg;
    assign status_rd_o = status_rd_reg;

endmodule
